instruction_fetch_unit: RTL and testbench

Front end of the 16-bit pipeline, and the producer of the decoder's instruction-history interface. Holds the PC and reads a synchronous instruction memory. Presents COMMAND, BeforeCOMMAND and TwoBeforeCOMMAND to the decode stage. Handles stall, taken-branch redirect (squash with NOP bubbles) and HLT/resume.

---
 rtl/instruction_fetch_unit_pkg.sv | 28 ++
 rtl/instruction_fetch_unit_history_shift.sv | 35 +++
 rtl/instruction_fetch_unit.sv | 108 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared instruction-format definitions for the fetch front end and the decoder.
package instruction_fetch_unit_pkg;

  localparam logic [15:0] NOP_WORD_DEFAULT = 16'hC0E0;
  localparam logic [1:0]  HLT_CLASS        = 2'b11;
  localparam logic [3:0]  HLT_OP3          = 4'b1111;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Field layout: [15:14] class, [13:11] rd, [10:8] rs, [7:4] op3, [3:0] low bits.
  typedef struct packed {
    logic [1:0] cls;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [3:0] op3;
    logic [3:0] low;
  } instr_t;

  function automatic logic is_hlt(input logic [15:0] word);
    instr_t f;
    f = instr_t'(word);
    return (f.cls == HLT_CLASS) && (f.op3 == HLT_OP3);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_history_shift.sv
// Three-deep instruction history (COMMAND, previous, two-before) with the pc/valid of COMMAND.
module instruction_fetch_unit_history_shift #(
  parameter logic [15:0] NOP_WORD = 16'hC0E0,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shift,
  input  logic [15:0] next_word,
  input  logic [15:0] next_pc,
  input  logic        next_valid,
  output logic [15:0] command,
  output logic [15:0] before_command,
  output logic [15:0] two_before_command,
  output logic [15:0] cmd_pc,
  output logic        cmd_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      command            <= NOP_WORD;
      before_command     <= NOP_WORD;
      two_before_command <= NOP_WORD;
      cmd_pc             <= RESET_PC;
      cmd_valid          <= 1'b0;
    end else if (shift) begin
      two_before_command <= before_command;
      before_command     <= command;
      command            <= next_word;
      cmd_pc             <= next_pc;
      cmd_valid          <= next_valid;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC, synchronous imem read, stall/redirect/halt control and decode history.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  input  logic        resume,
  output logic [15:0] COMMAND,
  output logic [15:0] BeforeCOMMAND,
  output logic [15:0] TwoBeforeCOMMAND,
  output logic [15:0] cmd_pc,
  output logic        cmd_valid,
  output logic        halted
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  fetch_pc_q;
  logic         valid_q;

  logic         running;
  logic         do_advance;
  logic         do_redirect;
  logic         do_resume;
  logic         hist_shift;
  logic [15:0]  hist_word;
  logic         hist_valid;

  assign running     = (state == RUN);
  assign do_redirect = running && redirect;
  assign do_advance  = running && !stall && !redirect;
  assign do_resume   = !running && resume;

  assign imem_en   = running && (!stall || redirect);
  assign imem_addr = pc;
  assign halted    = !running;

  // Redirect and resume both push a bubble; only a plain advance can carry a fetched word.
  always_comb begin
    hist_shift = do_advance || do_redirect || do_resume;
    hist_word  = NOP_WORD;
    hist_valid = 1'b0;
    if (do_advance && valid_q) begin
      hist_word  = imem_rdata;
      hist_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      state      <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            pc      <= redirect_target;
            valid_q <= 1'b0;
          end else if (!stall) begin
            fetch_pc_q <= pc;
            pc         <= pc + 16'd1;
            valid_q    <= 1'b1;
            if (valid_q && is_hlt(imem_rdata)) begin
              state <= HALT;
            end
          end
        end
        HALT: begin
          if (resume) begin
            state   <= RUN;
            pc      <= cmd_pc + 16'd1;
            valid_q <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  instruction_fetch_unit_history_shift #(
    .NOP_WORD(NOP_WORD),
    .RESET_PC(RESET_PC)
  ) u_history (
    .clk               (clk),
    .rst               (rst),
    .shift             (hist_shift),
    .next_word         (hist_word),
    .next_pc           (fetch_pc_q),
    .next_valid        (hist_valid),
    .command           (COMMAND),
    .before_command    (BeforeCOMMAND),
    .two_before_command(TwoBeforeCOMMAND),
    .cmd_pc            (cmd_pc),
    .cmd_valid         (cmd_valid)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a behavioural fetch model.
module tb_instruction_fetch_unit;

  localparam logic [15:0] NOP = 16'hC0E0;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_target;
  logic        resume;
  logic [15:0] command, before_command, two_before_command, cmd_pc;
  logic        cmd_valid, halted;

  logic [15:0] mem [0:65535];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_PC(16'h0000),
    .NOP_WORD(16'hC0E0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .resume          (resume),
    .COMMAND         (command),
    .BeforeCOMMAND   (before_command),
    .TwoBeforeCOMMAND(two_before_command),
    .cmd_pc          (cmd_pc),
    .cmd_valid       (cmd_valid),
    .halted          (halted)
  );

  // Synchronous instruction memory.
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic hlt_word(input logic [15:0] w);
    return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
  endfunction

  // Model: next address to fetch, one in-flight read slot, history of decoded words.
  logic [15:0] m_pc, m_fpc, m_cpc, m_w;
  logic [15:0] m_hist [3];
  logic        m_fv, m_cval, m_halt;
  logic        m_ok = 1'b0;

  task automatic m_push(input logic [15:0] w, input logic v, input logic [15:0] a);
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = w;
    m_cval    = v;
    m_cpc     = a;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 16'h0000; m_fpc = 16'h0000; m_fv = 1'b0; m_halt = 1'b0;
      m_hist = '{NOP, NOP, NOP}; m_cval = 1'b0; m_cpc = 16'h0000; m_ok = 1'b1;
    end else if (m_ok) begin
      if (m_halt) begin
        if (resume) begin
          m_halt = 1'b0;
          m_pc   = m_cpc + 16'd1;
          m_fv   = 1'b0;
          m_push(NOP, 1'b0, m_cpc);
        end
      end else if (redirect) begin
        m_push(NOP, 1'b0, m_cpc);
        m_pc = redirect_target;
        m_fv = 1'b0;
      end else if (!stall) begin
        m_w = m_fv ? mem[m_fpc] : NOP;
        m_push(m_w, m_fv, m_fpc);
        if (m_fv && hlt_word(m_w)) m_halt = 1'b1;
        m_fpc = m_pc;
        m_pc  = m_pc + 16'd1;
        m_fv  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("COMMAND", command, m_hist[0]);
      check("BeforeCOMMAND", before_command, m_hist[1]);
      check("TwoBeforeCOMMAND", two_before_command, m_hist[2]);
      check("cmd_valid", {15'b0, cmd_valid}, {15'b0, m_cval});
      check("halted", {15'b0, halted}, {15'b0, m_halt});
      check("imem_en", {15'b0, imem_en}, {15'b0, (!m_halt && (!stall || redirect))});
      check("imem_addr", imem_addr, m_pc);
      if (m_cval) check("cmd_pc", cmd_pc, m_cpc);
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; redirect = 1'b0; resume = 1'b0; redirect_target = 16'h0000;
  endtask

  task automatic fill_mem();
    logic [15:0] w;
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      if (hlt_word(w)) w[4] = 1'b0;
      mem[i] = w;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cmd"}, command, NOP);
    check({tag, "_before"}, before_command, NOP);
    check({tag, "_two"}, two_before_command, NOP);
    check({tag, "_pc"}, cmd_pc, 16'h0000);
    check({tag, "_valid"}, {15'b0, cmd_valid}, 16'h0000);
    check({tag, "_halted"}, {15'b0, halted}, 16'h0000);
  endtask

  task automatic redirect_case(input logic with_stall);
    rst = 1'b1;
    mem[16'h0040] = 16'hABCD;
    step(1);
    rst = 1'b0;
    step(3);
    check("redir_pre_cmd", command, 16'h2222);
    redirect = 1'b1; redirect_target = 16'h0040; stall = with_stall;
    step(1);
    idle();
    check("redir_bub1_cmd", command, NOP);
    check("redir_bub1_valid", {15'b0, cmd_valid}, 16'h0000);
    check("redir_bub1_before", before_command, 16'h2222);
    step(1);
    check("redir_bub2_cmd", command, NOP);
    check("redir_bub2_valid", {15'b0, cmd_valid}, 16'h0000);
    step(1);
    check("redir_tgt_cmd", command, 16'hABCD);
    check("redir_tgt_pc", cmd_pc, 16'h0040);
    check("redir_tgt_valid", {15'b0, cmd_valid}, 16'h0001);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    fill_mem();
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;

    // Reset state and startup latency
    step(2);
    check_reset_state("rst");
    rst = 1'b0;
    step(2);
    check("lat_cmd", command, 16'h1111);
    check("lat_pc", cmd_pc, 16'h0000);
    step(3);
    check("seq_cmd", command, 16'h4444);
    check("seq_before", before_command, 16'h3333);
    check("seq_two", two_before_command, 16'h2222);

    // Stall holds everything, no skip or duplicate
    rst = 1'b1; step(1); rst = 1'b0;
    step(3);
    check("stall_pre", command, 16'h2222);
    stall = 1'b1;
    #1;
    check("stall_en", {15'b0, imem_en}, 16'h0000);
    step(2);
    check("stall_hold_cmd", command, 16'h2222);
    check("stall_hold_before", before_command, 16'h1111);
    stall = 1'b0;
    step(1);
    check("stall_rel1", command, 16'h3333);
    step(1);
    check("stall_rel2", command, 16'h4444);
    check("stall_rel2_before", before_command, 16'h3333);

    redirect_case(1'b0);
    redirect_case(1'b1);

    // HLT, frozen outputs, resume
    rst = 1'b1;
    mem[2] = 16'hC0F0;
    step(1);
    rst = 1'b0;
    step(4);
    check("hlt_cmd", command, 16'hC0F0);
    check("hlt_halted", {15'b0, halted}, 16'h0001);
    check("hlt_en", {15'b0, imem_en}, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      redirect = 1'($urandom_range(0, 1));
      stall = 1'($urandom_range(0, 1));
      redirect_target = 16'($urandom);
      step(1);
      check("hlt_frozen_cmd", command, 16'hC0F0);
      check("hlt_frozen_pc", cmd_pc, 16'h0002);
    end
    idle();
    resume = 1'b1;
    step(1);
    resume = 1'b0;
    check("resume_bubble", command, NOP);
    check("resume_halted", {15'b0, halted}, 16'h0000);
    for (int k = 0; k < 4 && !cmd_valid; k++) step(1);
    check("resume_word", command, 16'h4444);
    check("resume_pc", cmd_pc, 16'h0003);

    // Reset while halted and while a redirect bubble is pending
    rst = 1'b1; step(1); rst = 1'b0;
    step(4);
    check("rst_halt_pre", {15'b0, halted}, 16'h0001);
    rst = 1'b1; step(1);
    check_reset_state("rst_halt");
    rst = 1'b0;
    step(3);
    redirect = 1'b1; redirect_target = 16'h0040;
    step(1);
    redirect = 1'b0; rst = 1'b1;
    step(1);
    check_reset_state("rst_redir");

    // Randomized traffic with planted HLTs, wrap-around targets and occasional resets
    fill_mem();
    for (int k = 0; k < 40; k++)
      mem[$urandom_range(0, 300)] = {2'b11, 6'($urandom), 4'hF, 4'($urandom)};
    step(1);
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      redirect = ($urandom_range(0, 9) == 0);
      redirect_target = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom_range(0, 300));
      resume = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step(1);
    end
    idle();
    rst = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
